// File: rtl/armv4_pkg.sv
// ---------------------------------------------------------------------------
// armv4_pkg
//   Shared types and helpers for the ARMv4 SWP/SWPB data-bus sequencer.
//   - swp_state_t : sequencer state encoding
//   - BE_WORD     : full-word byte enable
//   - rot_rd()    : ARMv4 unaligned-load rotate (right by 8*ofs)
//   - byte_be()   : single-lane byte enable for SWPB
// ---------------------------------------------------------------------------
package armv4_pkg;

  typedef enum logic [1:0] {
    SWP_IDLE = 2'd0,
    SWP_RD   = 2'd1,
    SWP_WR   = 2'd2
  } swp_state_t;

  localparam logic [3:0] BE_WORD = 4'hF;

  function automatic logic [31:0] rot_rd(input logic [31:0] data,
                                         input logic [1:0]  ofs);
    logic [31:0] r;
    case (ofs)
      2'd0:    r = data;
      2'd1:    r = {data[7:0],  data[31:8]};
      2'd2:    r = {data[15:0], data[31:16]};
      default: r = {data[23:0], data[31:24]};
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_be(input logic [1:0] ofs);
    return 4'b0001 << ofs;
  endfunction

endpackage

// File: rtl/swp_lane_fmt.sv
// ---------------------------------------------------------------------------
// swp_lane_fmt
//   Combinational lane formatting for SWP/SWPB.
//   Read side : word -> rotate right by 8*ofs; byte -> selected lane, zero-ext.
//   Write side: word -> Rm as-is with all lanes enabled;
//               byte -> Rm[7:0] replicated, single-lane enable.
// Ports
//   bus_rdata_i  raw read data from the bus
//   ofs_i        byte offset (address bits [1:0])
//   byte_i       1 = SWPB
//   rm_i         store data (Rm)
//   rd_fmt_o     formatted read value for writeback
//   wr_data_o    write-beat data
//   wr_be_o      write-beat byte enables
// ---------------------------------------------------------------------------
module swp_lane_fmt
  import armv4_pkg::*;
(
  input  logic [31:0] bus_rdata_i,
  input  logic [1:0]  ofs_i,
  input  logic        byte_i,
  input  logic [31:0] rm_i,
  output logic [31:0] rd_fmt_o,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_be_o
);

  logic [31:0] rot;

  // Rotating brings the addressed byte lane down to [7:0], so the byte
  // case reuses the same rotator instead of a separate lane mux.
  assign rot       = rot_rd(bus_rdata_i, ofs_i);
  assign rd_fmt_o  = byte_i ? {24'h0, rot[7:0]} : rot;
  assign wr_data_o = byte_i ? {4{rm_i[7:0]}} : rm_i;
  assign wr_be_o   = byte_i ? byte_be(ofs_i) : BE_WORD;

endmodule

// File: rtl/swp_mem_seq.sv
// ---------------------------------------------------------------------------
// swp_mem_seq
//   Data-bus sequencer for ARMv4 SWP/SWPB: an atomic read beat followed by
//   a write beat, returning the old memory value for writeback.
//   Optional feature macro: SWP_BUS_LOCK_EN (drives o_bus_lock across the
//   read/write pair; when undefined o_bus_lock is tied low).
// Ports
//   clk, rst_n            clock, async active-low reset
//   en                    gates acceptance of new requests
//   i_req/i_addr/i_wdata/i_byte   swap request from execute
//   o_busy                sequencer not idle
//   o_done/o_err/o_rdata  completion pulse, error flag, formatted old value
//   o_bus_*               data-bus request (valid/we/addr/wdata/be/lock)
//   i_bus_ready/i_bus_rdata/i_bus_err   data-bus response
// ---------------------------------------------------------------------------
module swp_mem_seq
  import armv4_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic          i_byte,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [31:0]   o_rdata,
  output logic          o_bus_valid,
  output logic          o_bus_we,
  output logic [AW-1:0] o_bus_addr,
  output logic [31:0]   o_bus_wdata,
  output logic [3:0]    o_bus_be,
  input  logic          i_bus_ready,
  input  logic [31:0]   i_bus_rdata,
  input  logic          i_bus_err,
  output logic          o_bus_lock
);

  swp_state_t  state_q;
  logic [1:0]  ofs_q;
  logic        byte_q;
  logic [31:0] rm_q;
  logic        busy_q, done_q, err_q;
  logic [31:0] rdata_q;
  logic        bv_q, bwe_q;
  logic [AW-1:0] baddr_q;
  logic [31:0] bwdata_q;
  logic [3:0]  bbe_q;

  logic        accept, beat_done;
  logic [31:0] rd_fmt, wr_data;
  logic [3:0]  wr_be;

  assign accept    = (state_q == SWP_IDLE) && en && i_req;
  assign beat_done = bv_q && i_bus_ready;

  swp_lane_fmt u_fmt (
    .bus_rdata_i (i_bus_rdata),
    .ofs_i       (ofs_q),
    .byte_i      (byte_q),
    .rm_i        (rm_q),
    .rd_fmt_o    (rd_fmt),
    .wr_data_o   (wr_data),
    .wr_be_o     (wr_be)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SWP_IDLE;
      ofs_q    <= 2'b00;
      byte_q   <= 1'b0;
      rm_q     <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      bv_q     <= 1'b0;
      bwe_q    <= 1'b0;
      baddr_q  <= '0;
      bwdata_q <= 32'h0;
      bbe_q    <= 4'h0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        SWP_IDLE: begin
          if (accept) begin
            state_q <= SWP_RD;
            ofs_q   <= i_addr[1:0];
            byte_q  <= i_byte;
            rm_q    <= i_wdata;
            busy_q  <= 1'b1;
            bv_q    <= 1'b1;
            bwe_q   <= 1'b0;
            baddr_q <= {i_addr[AW-1:2], 2'b00};
            bbe_q   <= BE_WORD;
          end
        end
        SWP_RD: begin
          if (beat_done) begin
            if (i_bus_err) begin
              // Abort the swap: memory was never written, report the error.
              state_q <= SWP_IDLE;
              busy_q  <= 1'b0;
              bv_q    <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              // Valid stays high: the write beat follows with no idle gap.
              state_q  <= SWP_WR;
              rdata_q  <= rd_fmt;
              bwe_q    <= 1'b1;
              bwdata_q <= wr_data;
              bbe_q    <= wr_be;
            end
          end
        end
        SWP_WR: begin
          if (beat_done) begin
            state_q <= SWP_IDLE;
            busy_q  <= 1'b0;
            bv_q    <= 1'b0;
            bwe_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= i_bus_err;
          end
        end
        default: state_q <= SWP_IDLE;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_rdata     = rdata_q;
  assign o_bus_valid = bv_q;
  assign o_bus_we    = bwe_q;
  assign o_bus_addr  = baddr_q;
  assign o_bus_wdata = bwdata_q;
  assign o_bus_be    = bbe_q;

`ifdef SWP_BUS_LOCK_EN
  logic lock_q;

  // Lock tracks the whole read/write pair: raised with the read beat's
  // valid, dropped after the final (write or erroring read) beat completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lock_q <= 1'b0;
    else if (accept)
      lock_q <= 1'b1;
    else if (beat_done && (state_q == SWP_WR || i_bus_err))
      lock_q <= 1'b0;
  end

  assign o_bus_lock = lock_q;
`else
  assign o_bus_lock = 1'b0;
`endif

endmodule

// File: tb/tb_swp_mem_seq.sv
module tb_swp_mem_seq;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [31:0]   i_wdata = 32'h0;
  logic          i_byte = 1'b0;
  logic          o_busy, o_done, o_err;
  logic [31:0]   o_rdata;
  logic          o_bus_valid, o_bus_we, o_bus_lock;
  logic [AW-1:0] o_bus_addr;
  logic [31:0]   o_bus_wdata;
  logic [3:0]    o_bus_be;
  logic          i_bus_ready, i_bus_err;
  logic [31:0]   i_bus_rdata;

  swp_mem_seq #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .i_req(i_req), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_byte(i_byte), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_rdata(o_rdata), .o_bus_valid(o_bus_valid),
    .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .o_bus_be(o_bus_be), .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
    .i_bus_err(i_bus_err), .o_bus_lock(o_bus_lock)
  );

  always #5 clk = ~clk;

  // ---------------- memory / bus responder model ----------------
  logic [31:0] mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = 8'h0;
  logic [31:0] bd_data = 32'h0;
  int          rdy_wait = 0;
  logic        err_rd = 1'b0, err_wr = 1'b0;
  int          wcnt;

  assign i_bus_ready = (wcnt == rdy_wait);
  assign i_bus_rdata = mem[o_bus_addr[9:2]];
  assign i_bus_err   = o_bus_we ? err_wr : err_rd;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt <= 0;
    else if (o_bus_valid) wcnt <= i_bus_ready ? 0 : wcnt + 1;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (o_bus_valid && i_bus_ready && o_bus_we && !i_bus_err)
      for (int b = 0; b < 4; b++)
        if (o_bus_be[b]) mem[o_bus_addr[9:2]][8*b +: 8] <= o_bus_wdata[8*b +: 8];
  end

  // ---------------- scoreboard / trace ----------------
  typedef struct { logic [31:0] rd; logic err; } exp_t;
  exp_t        sb[$];
  logic [32:0] got[$];
  exp_t        e;
  logic [32:0] g;
  int          npass = 0, ntot = 0;

  logic [31:0] tr_valid, tr_we, tr_busy, tr_done, tr_lock;
  logic [31:0] tr_addr  [0:31];
  logic [31:0] tr_wdata [0:31];
  logic [3:0]  tr_be    [0:31];

  task automatic preload(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk); bd_we = 1'b1; bd_idx = idx; bd_data = d;
    @(posedge clk); #1 bd_we = 1'b0;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] w, input logic b,
                       input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    en = 1'b1; i_req = 1'b1; i_addr = a; i_wdata = w; i_byte = b;
    sb.push_back('{exp_rd, exp_err});
    @(posedge clk); #1 i_req = 1'b0;
  endtask

  // Cycle k = k-th negedge after the accepting edge.
  task automatic collect(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      @(negedge clk);
      tr_valid[k] = o_bus_valid; tr_we[k] = o_bus_we; tr_busy[k] = o_busy;
      tr_done[k] = o_done; tr_lock[k] = o_bus_lock;
      tr_addr[k] = o_bus_addr; tr_wdata[k] = o_bus_wdata; tr_be[k] = o_bus_be;
      if (o_done) got.push_back({o_err, o_rdata});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    ntot++; if ({o_busy, o_done, o_err, o_bus_valid, o_bus_we, o_bus_lock} !== 6'b0) $display("FAIL reset_ctrl got %b exp 000000", {o_busy, o_done, o_err, o_bus_valid, o_bus_we, o_bus_lock}); else npass++;
    ntot++; if (o_rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", o_rdata); else npass++;
    ntot++; if (o_bus_addr !== '0) $display("FAIL reset_addr got %h exp 0", o_bus_addr); else npass++;
    ntot++; if (o_bus_wdata !== 32'h0) $display("FAIL reset_wdata got %h exp 0", o_bus_wdata); else npass++;
    ntot++; if (o_bus_be !== 4'h0) $display("FAIL reset_be got %h exp 0", o_bus_be); else npass++;
  endtask

  task automatic test_word_swap();
    preload(8'h40, 32'h11223344);
    start(32'h100, 32'hDEADBEEF, 1'b0, 32'h11223344, 1'b0);
    collect(1, 5);
    ntot++; if ({tr_valid[1], tr_we[1], tr_be[1]} !== 6'b101111) $display("FAIL word_rd_beat got %b exp 101111", {tr_valid[1], tr_we[1], tr_be[1]}); else npass++;
    ntot++; if (tr_addr[1] !== 32'h100) $display("FAIL word_rd_addr got %h exp 00000100", tr_addr[1]); else npass++;
    ntot++; if ({tr_valid[2], tr_we[2], tr_be[2]} !== 6'b111111) $display("FAIL word_wr_beat got %b exp 111111", {tr_valid[2], tr_we[2], tr_be[2]}); else npass++;
    ntot++; if (tr_wdata[2] !== 32'hDEADBEEF) $display("FAIL word_wdata got %h exp deadbeef", tr_wdata[2]); else npass++;
    ntot++; if (tr_done[5:1] !== 5'b00100) $display("FAIL word_done_cycle got %b exp 00100", tr_done[5:1]); else npass++;
    ntot++; if (tr_busy[3:1] !== 3'b011) $display("FAIL word_busy got %b exp 011", tr_busy[3:1]); else npass++;
`ifdef SWP_BUS_LOCK_EN
    ntot++; if (tr_lock[4:1] !== 4'b0011) $display("FAIL word_lock got %b exp 0011", tr_lock[4:1]); else npass++;
`else
    ntot++; if (tr_lock[5:1] !== 5'b0) $display("FAIL word_lock got %b exp 00000", tr_lock[5:1]); else npass++;
`endif
    ntot++; if (mem[8'h40] !== 32'hDEADBEEF) $display("FAIL word_mem got %h exp deadbeef", mem[8'h40]); else npass++;
    e = sb.pop_front(); g = (got.size() != 0) ? got.pop_front() : 'x;
    ntot++; if (g !== {e.err, e.rd}) $display("FAIL word_sb got %h exp %h", g, {e.err, e.rd}); else npass++;
  endtask

  task automatic test_swpb();
    preload(8'h40, 32'h11223344);
    start(32'h103, 32'h000000AB, 1'b1, 32'h00000011, 1'b0);
    collect(1, 5);
    ntot++; if ({tr_we[2], tr_be[2]} !== 5'b11000) $display("FAIL swpb_be got %b exp 11000", {tr_we[2], tr_be[2]}); else npass++;
    ntot++; if (tr_wdata[2] !== 32'hABABABAB) $display("FAIL swpb_wdata got %h exp abababab", tr_wdata[2]); else npass++;
    ntot++; if (mem[8'h40] !== 32'hAB223344) $display("FAIL swpb_mem got %h exp ab223344", mem[8'h40]); else npass++;
    e = sb.pop_front(); g = (got.size() != 0) ? got.pop_front() : 'x;
    ntot++; if (g !== {e.err, e.rd}) $display("FAIL swpb_sb got %h exp %h", g, {e.err, e.rd}); else npass++;
  endtask

  task automatic test_unaligned();
    preload(8'h40, 32'h11223344);
    start(32'h102, 32'h55667788, 1'b0, 32'h33441122, 1'b0);
    collect(1, 5);
    ntot++; if ({tr_addr[1], tr_addr[2]} !== {32'h100, 32'h100}) $display("FAIL unal_addr got %h %h exp 00000100", tr_addr[1], tr_addr[2]); else npass++;
    ntot++; if (mem[8'h40] !== 32'h55667788) $display("FAIL unal_mem got %h exp 55667788", mem[8'h40]); else npass++;
    e = sb.pop_front(); g = (got.size() != 0) ? got.pop_front() : 'x;
    ntot++; if (g !== {e.err, e.rd}) $display("FAIL unal_sb got %h exp %h", g, {e.err, e.rd}); else npass++;
  endtask

  task automatic test_wait_states();
    logic stable;
    preload(8'h41, 32'hA5A5A5A5);
    rdy_wait = 3;
    start(32'h104, 32'h01020304, 1'b0, 32'hA5A5A5A5, 1'b0);
    collect(1, 12);
    rdy_wait = 0;
    stable = 1'b1;
    for (int k = 2; k <= 4; k++)
      if ({tr_valid[k], tr_we[k], tr_be[k], tr_addr[k]} !== {tr_valid[1], tr_we[1], tr_be[1], tr_addr[1]}) stable = 1'b0;
    for (int k = 6; k <= 8; k++)
      if ({tr_valid[k], tr_we[k], tr_be[k], tr_addr[k], tr_wdata[k]} !== {tr_valid[5], tr_we[5], tr_be[5], tr_addr[5], tr_wdata[5]}) stable = 1'b0;
    ntot++; if (stable !== 1'b1) $display("FAIL wait_stable got %b exp 1", stable); else npass++;
    ntot++; if ({tr_valid[8:1], tr_we[8:1]} !== 16'hFF_F0) $display("FAIL wait_beats got %h exp fff0", {tr_valid[8:1], tr_we[8:1]}); else npass++;
    ntot++; if (tr_done[12:1] !== 12'h100) $display("FAIL wait_done got %h exp 100", tr_done[12:1]); else npass++;
    ntot++; if (tr_busy[12:1] !== 12'h0FF) $display("FAIL wait_busy got %h exp 0ff", tr_busy[12:1]); else npass++;
    ntot++; if (mem[8'h41] !== 32'h01020304) $display("FAIL wait_mem got %h exp 01020304", mem[8'h41]); else npass++;
    e = sb.pop_front(); g = (got.size() != 0) ? got.pop_front() : 'x;
    ntot++; if (g !== {e.err, e.rd}) $display("FAIL wait_sb got %h exp %h", g, {e.err, e.rd}); else npass++;
  endtask

  task automatic test_read_err();
    preload(8'h42, 32'h77777777);
    err_rd = 1'b1;
    start(32'h108, 32'h12345678, 1'b0, 32'h0, 1'b1);
    collect(1, 5);
    err_rd = 1'b0;
    ntot++; if ({tr_valid[5:1], tr_we[5:1]} !== 10'b00001_00000) $display("FAIL rerr_beats got %b exp 0000100000", {tr_valid[5:1], tr_we[5:1]}); else npass++;
    ntot++; if (tr_done[5:1] !== 5'b00010) $display("FAIL rerr_done got %b exp 00010", tr_done[5:1]); else npass++;
`ifdef SWP_BUS_LOCK_EN
    ntot++; if (tr_lock[3:1] !== 3'b001) $display("FAIL rerr_lock got %b exp 001", tr_lock[3:1]); else npass++;
`endif
    ntot++; if (mem[8'h42] !== 32'h77777777) $display("FAIL rerr_mem got %h exp 77777777", mem[8'h42]); else npass++;
    e = sb.pop_front(); g = (got.size() != 0) ? got.pop_front() : 'x;
    ntot++; if (g[32] !== e.err) $display("FAIL rerr_err got %b exp %b", g[32], e.err); else npass++;
  endtask

  task automatic test_reset_mid();
    preload(8'h43, 32'h01010101);
    rdy_wait = 3;
    start(32'h10C, 32'hFFFFFFFF, 1'b0, 32'h01010101, 1'b0);
    collect(1, 6);
    ntot++; if ({tr_valid[6], tr_we[6]} !== 2'b11) $display("FAIL rmid_in_wr got %b exp 11", {tr_valid[6], tr_we[6]}); else npass++;
    #2 rst_n = 1'b0;
    #1;
    ntot++; if ({o_busy, o_done, o_err, o_bus_valid, o_bus_we, o_bus_lock} !== 6'b0) $display("FAIL rmid_ctrl got %b exp 000000", {o_busy, o_done, o_err, o_bus_valid, o_bus_we, o_bus_lock}); else npass++;
    ntot++; if ({o_rdata, o_bus_addr, o_bus_wdata, o_bus_be} !== '0) $display("FAIL rmid_data got %h %h %h %h exp 0", o_rdata, o_bus_addr, o_bus_wdata, o_bus_be); else npass++;
    sb.delete(); got.delete();
    rdy_wait = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    ntot++; if (mem[8'h43] !== 32'h01010101) $display("FAIL rmid_nowrite got %h exp 01010101", mem[8'h43]); else npass++;
    start(32'h10C, 32'h2468ACE0, 1'b0, 32'h01010101, 1'b0);
    collect(1, 5);
    ntot++; if (tr_done[5:1] !== 5'b00100) $display("FAIL rmid_after_done got %b exp 00100", tr_done[5:1]); else npass++;
    ntot++; if (mem[8'h43] !== 32'h2468ACE0) $display("FAIL rmid_after_mem got %h exp 2468ace0", mem[8'h43]); else npass++;
    e = sb.pop_front(); g = (got.size() != 0) ? got.pop_front() : 'x;
    ntot++; if (g !== {e.err, e.rd}) $display("FAIL rmid_sb got %h exp %h", g, {e.err, e.rd}); else npass++;
  endtask

  task automatic test_back_to_back();
    preload(8'h44, 32'hCAFEF00D);
    preload(8'h45, 32'h0BADBEEF);
    @(negedge clk);
    en = 1'b1; i_req = 1'b1; i_addr = 32'h110; i_wdata = 32'h11111111; i_byte = 1'b0;
    sb.push_back('{32'hCAFEF00D, 1'b0});
    @(posedge clk); #1;
    // Request stays high; the second swap is taken in the done cycle.
    i_addr = 32'h114; i_wdata = 32'h22222222;
    sb.push_back('{32'h0BADBEEF, 1'b0});
    collect(1, 4);
    i_req = 1'b0;
    collect(5, 8);
    ntot++; if (tr_done[8:1] !== 8'b00100100) $display("FAIL b2b_done got %b exp 00100100", tr_done[8:1]); else npass++;
    ntot++; if (tr_addr[4] !== 32'h114) $display("FAIL b2b_addr2 got %h exp 00000114", tr_addr[4]); else npass++;
    ntot++; if ({mem[8'h44], mem[8'h45]} !== {32'h11111111, 32'h22222222}) $display("FAIL b2b_mem got %h %h exp 11111111 22222222", mem[8'h44], mem[8'h45]); else npass++;
    for (int n = 0; n < 2; n++) begin
      e = sb.pop_front(); g = (got.size() != 0) ? got.pop_front() : 'x;
      ntot++; if (g !== {e.err, e.rd}) $display("FAIL b2b_sb%0d got %h exp %h", n, g, {e.err, e.rd}); else npass++;
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_word_swap();
    test_swpb();
    test_unaligned();
    test_wait_states();
    test_read_err();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
